// File: rtl/scr1_dmem_port_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scr1_dmem_port_arb : LSU-priority arbiter sharing one DMEM port, with a
//                      starvation guard for the secondary master. Rev 1.0
// ----------------------------------------------------------------------------

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_arb_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_port_arb
  import scr1_dmem_arb_pkg::*;
#(
  parameter int unsigned SCR1_ARB_STARVE_LIMIT = 4,
  parameter int unsigned SCR1_ARB_CNT_W        = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // requester 0 (LSU)
  input  logic                         m0_req_i,
  input  type_scr1_mem_cmd_e           m0_cmd_i,
  input  type_scr1_mem_width_e         m0_width_i,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] m0_addr_i,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] m0_wdata_i,
  output logic                         m0_req_ack_o,
  output logic [`SCR1_DMEM_DWIDTH-1:0] m0_rdata_o,
  output type_scr1_mem_resp_e          m0_resp_o,
  // requester 1 (secondary master)
  input  logic                         m1_req_i,
  input  type_scr1_mem_cmd_e           m1_cmd_i,
  input  type_scr1_mem_width_e         m1_width_i,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] m1_addr_i,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] m1_wdata_i,
  output logic                         m1_req_ack_o,
  output logic [`SCR1_DMEM_DWIDTH-1:0] m1_rdata_o,
  output type_scr1_mem_resp_e          m1_resp_o,
  // shared DMEM port
  output logic                         dmem_req_o,
  output type_scr1_mem_cmd_e           dmem_cmd_o,
  output type_scr1_mem_width_e         dmem_width_o,
  output logic [`SCR1_DMEM_AWIDTH-1:0] dmem_addr_o,
  output logic [`SCR1_DMEM_DWIDTH-1:0] dmem_wdata_o,
  input  logic                         dmem_req_ack_i,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] dmem_rdata_i,
  input  type_scr1_mem_resp_e          dmem_resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  localparam logic [SCR1_ARB_CNT_W-1:0] CNT_LIMIT = SCR1_ARB_CNT_W'(SCR1_ARB_STARVE_LIMIT);

  state_e                    state;
  logic [SCR1_ARB_CNT_W-1:0] starve_cnt;
  logic                      lock;
  logic                      lock_id;

  logic                      gnt_vld;
  logic                      gnt_id;
  logic                      accept;
  logic                      cnt_at_limit;

  assign cnt_at_limit = (starve_cnt == CNT_LIMIT);

  // A presented-but-unacked request keeps the grant so DMEM sees stable fields.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE) begin
      if (lock && (lock_id ? m1_req_i : m0_req_i)) begin
        gnt_vld = 1'b1;
        gnt_id  = lock_id;
      end else if (m1_req_i && (!m0_req_i || cnt_at_limit)) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end else if (m0_req_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
    end
  end

  assign accept = gnt_vld & dmem_req_ack_i;

  always_comb begin
    dmem_req_o = gnt_vld;
    if (gnt_vld && gnt_id) begin
      dmem_cmd_o   = m1_cmd_i;
      dmem_width_o = m1_width_i;
      dmem_addr_o  = m1_addr_i;
      dmem_wdata_o = m1_wdata_i;
    end else begin
      dmem_cmd_o   = m0_cmd_i;
      dmem_width_o = m0_width_i;
      dmem_addr_o  = m0_addr_i;
      dmem_wdata_o = m0_wdata_i;
    end
  end

  // Responses are only routed to the owner of the in-flight transaction.
  always_comb begin
    m0_req_ack_o = accept & ~gnt_id;
    m1_req_ack_o = accept &  gnt_id;
    m0_resp_o    = SCR1_MEM_RESP_NOTRDY;
    m1_resp_o    = SCR1_MEM_RESP_NOTRDY;
    m0_rdata_o   = '0;
    m1_rdata_o   = '0;
    case (state)
      BUSY0: begin
        m0_resp_o  = dmem_resp_i;
        m0_rdata_o = dmem_rdata_i;
      end
      BUSY1: begin
        m1_resp_o  = dmem_resp_i;
        m1_rdata_o = dmem_rdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lock       <= 1'b0;
      lock_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            lock    <= ~dmem_req_ack_i;
            lock_id <= gnt_id;
          end else begin
            lock    <= 1'b0;
          end
          if (accept) begin
            state <= gnt_id ? BUSY1 : BUSY0;
            // Only LSU wins that bypass a waiting requester 1 count toward starvation.
            if (!gnt_id && m1_req_i) begin
              if (!cnt_at_limit) begin
                starve_cnt <= starve_cnt + SCR1_ARB_CNT_W'(1);
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (dmem_resp_i != SCR1_MEM_RESP_NOTRDY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
